subbytes_seq: RTL and testbench
===============================

SUBBYTES_SEQ -- requirements
Module: subbytes_seq

Interface
REQ-001 SHALL have parameter: KEY_PRIO, 1, 1 = key port wins contention with anti-starvation alternation; 0 = key port served only when no state word is pending.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, as follows.
REQ-003 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port: st_valid  in  1  128-bit state offered.
REQ-006 SHALL have port: st_ready  out  1  engine accepts state.
REQ-007 SHALL have port: st_data  in  128  input state; word 0 = [127:96], word 3 = [31:0].
REQ-008 SHALL have port: out_valid  out  1  substituted state available.
REQ-009 SHALL have port: out_ready  in  1  consumer takes result.
REQ-010 SHALL have port: out_data  out  128  SubBytes(st_data), same byte order.
REQ-011 SHALL have port: kw_req  in  1  key-expansion SubWord request.
REQ-012 SHALL have port: kw_word  in  32  word to substitute.
REQ-013 SHALL have port: kw_gnt  out  1  combinational grant; kw_word is sampled this cycle.
REQ-014 SHALL have port: kw_valid  out  1  one-cycle pulse; kw_result valid.
REQ-015 SHALL have port: kw_result  out  32  SubWord(kw_word), registered.

Function
REQ-016 SHALL time-share one 32-bit S-box column (four byte S-boxes, combinational) between state words and key requests; at most one word per cycle.
REQ-017 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE; word index idx is 2 bits, 0..3.
REQ-018 SHALL drive st_ready=1 only in IDLE; on st_valid&st_ready capture st_data, set idx=0, and go to BUSY.
REQ-019 SHALL, in BUSY when the column is granted to state, write S(word idx) into out_data word idx and increment idx; after idx=3, go to DONE.
REQ-020 SHALL stall idx in BUSY when the column goes to the key port.
REQ-021 SHALL hold out_valid=1 and out_data stable in DONE until out_valid&out_ready, then go to IDLE; st_ready rises the following cycle.
REQ-022 SHALL, with no contention, accept in cycle 0, process words in cycles 1-4, and assert out_valid in cycle 5; each key grant in BUSY adds exactly 1 cycle.
REQ-023 SHALL arbitrate with KEY_PRIO=1: kw_gnt = kw_req, except in BUSY when the previous cycle was a key grant, in which case state wins.
REQ-024 SHALL arbitrate with KEY_PRIO=0: kw_gnt = kw_req outside BUSY and 0 in BUSY.
REQ-025 SHALL assert kw_valid and update kw_result in the cycle after kw_gnt; kw_result holds its last value otherwise.
REQ-026 SHALL leave requester behaviour to the requester: kw_req held until granted, kw_word stable only in the grant cycle.
REQ-027 SHALL treat simultaneous kw_req in IDLE/DONE and st accept as non-conflicting; both proceed.
REQ-028 SHALL ignore st_valid outside IDLE and out_ready outside DONE.

Reset
REQ-029 SHALL, on rst_n low, immediately set: FSM=IDLE, idx=0, last-grant-was-key=0, out_valid=0, kw_valid=0, out_data=0, kw_result=0.
REQ-030 SHALL, on reset mid-operation, discard the in-flight block and any pending key result; no output pulses until new requests arrive.
REQ-031 SHALL deassert reset asynchronously; operation begins on the first clk edge after release.

Structure
REQ-032 SHALL place the FSM state enum, WORDS=4, BYTE_W=8 and WORD_W=32 in shared package aes_pkg.
REQ-033 SHALL use one sub-module, sbox_word (32-bit in/out, four existing Sbox instances), instantiated once.
REQ-034 SHALL contain no other S-box instances; total RTL 120-400 lines.

Verification
REQ-035 SHALL cover: st_data=193de3bea0f4e22b9ac68d2ae9f84808, no kw_req -> out_valid in cycle 5 with out_data=d42711aee0bf98f1b8b45de51e415230.
REQ-036 SHALL cover: kw_req in IDLE with kw_word=cf4f3c09 -> kw_gnt same cycle; next cycle kw_valid=1 and kw_result=8a84eb01.
REQ-037 SHALL cover: KEY_PRIO=1 with kw_req held high through BUSY -> grants alternate key/state, out_valid in cycle 9, and the result equals REQ-035.
REQ-038 SHALL cover: KEY_PRIO=0 with kw_req asserted in cycle 2 -> kw_gnt=0 in cycles 2-4, kw_gnt=1 in cycle 5 (DONE), and out_valid in cycle 5.
REQ-039 SHALL cover: out_ready low for 3 cycles in DONE -> out_data stable and st_ready=0; st_ready=1 the cycle after the handshake.
REQ-040 SHALL cover: rst_n pulsed low in cycle 3 of BUSY -> out_valid never asserts for that block, and a new block of all 00 bytes yields all 63 bytes.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the SubBytes sequencer state encoding.
// Contents:
//   WORDS / BYTE_W / WORD_W  - geometry of a 128-bit AES state
//   LAST_IDX                 - index of the final column word
//   fsm_e                    - sequencer states IDLE / BUSY / DONE
package aes_pkg;
    localparam int WORDS  = 4;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    localparam logic [1:0] LAST_IDX = 2'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;
endpackage

// File: rtl/subbytes_seq_sbox_word.sv
// Byte S-box and a four-byte S-box column.
// Sbox:      a_i [7:0] byte in, s_o [7:0] substituted byte (combinational ROM).
// sbox_word: w_i [31:0] word in, s_o [31:0] per-byte substitution (combinational).
module Sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    // Entry 0 sits in the leftmost (most significant) position.
    localparam logic [0:255][7:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign s_o = SBOX_TBL[a_i];
endmodule

module sbox_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] w_i,
    output logic [WORD_W-1:0] s_o
);
    for (genvar b = 0; b < WORD_W / BYTE_W; b++) begin : g_byte
        Sbox u_sbox (
            .a_i (w_i[b*BYTE_W +: BYTE_W]),
            .s_o (s_o[b*BYTE_W +: BYTE_W])
        );
    end
endmodule

// File: rtl/subbytes_seq.sv
// Word-serial AES SubBytes engine sharing one S-box column with a
// key-expansion SubWord port.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   st_valid/st_ready/st_data       128-bit state in (word 0 = [127:96])
//   out_valid/out_ready/out_data    substituted state out, held until taken
//   kw_req/kw_word/kw_gnt           SubWord request; kw_word sampled in grant cycle
//   kw_valid/kw_result              registered SubWord result, pulse the cycle after grant
// KEY_PRIO=1: key port wins, but never twice in a row while a block is busy.
// KEY_PRIO=0: key port only served outside BUSY.
import aes_pkg::*;

module subbytes_seq #(
    parameter bit KEY_PRIO = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [WORDS*WORD_W-1:0] st_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORDS*WORD_W-1:0] out_data,
    input  logic                   kw_req,
    input  logic [WORD_W-1:0]      kw_word,
    output logic                   kw_gnt,
    output logic                   kw_valid,
    output logic [WORD_W-1:0]      kw_result
);
    fsm_e                         state_q, state_d;
    logic [1:0]                   idx_q, idx_d;
    logic                         last_key_q;
    logic [WORDS-1:0][WORD_W-1:0] in_q, out_q;
    logic                         kw_valid_q;
    logic [WORD_W-1:0]            kw_result_q;
    logic [WORD_W-1:0]            col_in, col_out;
    logic                         busy, st_use;

    assign busy = (state_q == ST_BUSY);

    always_comb begin
        if (KEY_PRIO) kw_gnt = kw_req & ~(busy & last_key_q);
        else          kw_gnt = kw_req & ~busy;
    end

    // The state side only consumes the column in BUSY cycles the key port loses.
    assign st_use = busy & ~kw_gnt;

    // Word 0 lives in the top 32 bits, hence the reversed word index.
    assign col_in = kw_gnt ? kw_word : in_q[LAST_IDX - idx_q];

    sbox_word u_col (
        .w_i (col_in),
        .s_o (col_out)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: if (st_valid) begin
                state_d = ST_BUSY;
                idx_d   = 2'd0;
            end
            ST_BUSY: if (st_use) begin
                idx_d = idx_q + 2'd1;
                if (idx_q == LAST_IDX) state_d = ST_DONE;
            end
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            last_key_q  <= 1'b0;
            in_q        <= '0;
            out_q       <= '0;
            kw_valid_q  <= 1'b0;
            kw_result_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_key_q <= kw_gnt;
            kw_valid_q <= kw_gnt;
            if (kw_gnt)               kw_result_q <= col_out;
            if (st_valid && st_ready) in_q        <= st_data;
            if (st_use)               out_q[LAST_IDX - idx_q] <= col_out;
        end
    end

    assign st_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_q;
    assign kw_valid  = kw_valid_q;
    assign kw_result = kw_result_q;
endmodule

// File: tb/tb_subbytes_seq.sv
module tb_subbytes_seq;
    logic         clk, rst_n, st_valid, out_ready, kw_req;
    logic [127:0] st_data;
    logic [31:0]  kw_word;
    logic         st_ready1, out_valid1, kw_gnt1, kw_valid1;
    logic [127:0] out_data1;
    logic [31:0]  kw_result1;
    logic         st_ready0, out_valid0, kw_gnt0, kw_valid0;
    logic [127:0] out_data0;
    logic [31:0]  kw_result0;

    int n_pass = 0;
    int n_tot  = 0;
    logic [7:0] sbox_m [256];

    subbytes_seq #(.KEY_PRIO(1'b1)) u_p1 (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready1), .st_data(st_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .kw_req(kw_req), .kw_word(kw_word), .kw_gnt(kw_gnt1), .kw_valid(kw_valid1), .kw_result(kw_result1)
    );
    subbytes_seq #(.KEY_PRIO(1'b0)) u_p0 (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready0), .st_data(st_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .kw_req(kw_req), .kw_word(kw_word), .kw_gnt(kw_gnt0), .kw_valid(kw_valid0), .kw_result(kw_result0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---- reference model: S-box from GF(2^8) inverse + affine map ----
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox_m[w[8*b +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = sub_word(d[32*k +: 32]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; st_valid = 1'b0; kw_req = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_ov1", out_valid1, 1'b0);
        chk("rst_kv1", kw_valid1, 1'b0);
        chk("rst_od1", out_data1, 128'h0);
        chk("rst_kr1", kw_result1, 32'h0);
        chk("rst_ov0", out_valid0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    localparam logic [127:0] VEC_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] VEC_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    initial begin
        logic [7:0]   inv;
        logic [127:0] d, exp_d;
        logic [31:0]  w, prev_w;
        logic         prev_g, e;
        int           cnt, k;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end

        rst_n = 1'b1; st_valid = 1'b0; out_ready = 1'b0; kw_req = 1'b0;
        st_data = '0; kw_word = '0;
        #2;
        do_reset();
        chk("rst_sr1", st_ready1, 1'b1);

        // Known vector, no key traffic: out_valid exactly in cycle 5.
        st_valid = 1'b1; st_data = VEC_IN; out_ready = 1'b1; #1;
        chk("a_sr", st_ready1, 1'b1);
        tick(); st_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1; chk("a_ov_early", out_valid1, 1'b0);
            tick();
        end
        #1;
        chk("a_ov1", out_valid1, 1'b1);
        chk("a_od1", out_data1, VEC_OUT);
        chk("a_od0", out_data0, VEC_OUT);
        chk("a_model", sub_state(VEC_IN), VEC_OUT);
        tick(); #1;
        chk("a_sr_after", st_ready1, 1'b1);
        chk("a_ov_after", out_valid1, 1'b0);

        // Key request in IDLE.
        kw_req = 1'b1; kw_word = 32'hcf4f3c09; #1;
        chk("b_gnt1", kw_gnt1, 1'b1);
        chk("b_gnt0", kw_gnt0, 1'b1);
        tick(); kw_req = 1'b0; #1;
        chk("b_kv1", kw_valid1, 1'b1);
        chk("b_kr1", kw_result1, 32'h8a84eb01);
        chk("b_kr0", kw_result0, sub_word(32'hcf4f3c09));
        tick(); #1;
        chk("b_kv_pulse", kw_valid1, 1'b0);
        chk("b_kr_hold", kw_result1, 32'h8a84eb01);

        // Key request held through BUSY: alternating grants on KEY_PRIO=1.
        do_reset();
        st_valid = 1'b1; st_data = VEC_IN; out_ready = 1'b1;
        tick(); st_valid = 1'b0; kw_req = 1'b1;
        prev_g = 1'b0; prev_w = '0;
        for (int c = 1; c <= 8; c++) begin
            w = $urandom; kw_word = w; #1;
            e = (c % 2 == 1);
            chk("c_gnt1", kw_gnt1, e);
            chk("c_ov1", out_valid1, 1'b0);
            chk("c_kv1", kw_valid1, prev_g);
            if (prev_g) chk("c_kr1", kw_result1, sub_word(prev_w));
            chk("c_gnt0", kw_gnt0, c >= 5);
            prev_g = e; prev_w = w;
            tick();
        end
        kw_req = 1'b0; #1;
        chk("c_ov1_c9", out_valid1, 1'b1);
        chk("c_od1", out_data1, VEC_OUT);
        chk("c_kv1_c9", kw_valid1, 1'b0);
        tick();

        // KEY_PRIO=0: request from cycle 2 waits until DONE.
        do_reset();
        d = {$urandom, $urandom, $urandom, $urandom};
        st_valid = 1'b1; st_data = d; out_ready = 1'b1;
        tick(); st_valid = 1'b0;
        tick(); kw_req = 1'b1;
        w = '0;
        for (int c = 2; c <= 5; c++) begin
            kw_word = $urandom; #1;
            if (c == 5) w = kw_word;
            chk("d_gnt0", kw_gnt0, c == 5);
            chk("d_ov0", out_valid0, c == 5);
            if (c == 5) chk("d_od0", out_data0, sub_state(d));
            tick();
        end
        kw_req = 1'b0; #1;
        chk("d_kv0", kw_valid0, 1'b1);
        chk("d_kr0", kw_result0, sub_word(w));

        // Back-pressure in DONE, plus key request alongside the accept.
        do_reset();
        d = {$urandom, $urandom, $urandom, $urandom};
        w = $urandom;
        st_valid = 1'b1; st_data = d; kw_req = 1'b1; kw_word = w; #1;
        chk("e_gnt_idle", kw_gnt1, 1'b1);
        chk("e_sr", st_ready1, 1'b1);
        tick(); st_valid = 1'b0; kw_req = 1'b0; #1;
        chk("e_kr", kw_result1, sub_word(w));
        repeat (4) tick();
        for (int c = 5; c <= 7; c++) begin
            st_valid = 1'b1; st_data = ~d; #1;
            chk("e_ov_hold", out_valid1, 1'b1);
            chk("e_od_hold", out_data1, sub_state(d));
            chk("e_sr_low", st_ready1, 1'b0);
            tick();
        end
        st_valid = 1'b0; out_ready = 1'b1; #1;
        chk("e_ov_c8", out_valid1, 1'b1);
        chk("e_od_c8", out_data1, sub_state(d));
        tick(); out_ready = 1'b0; #1;
        chk("e_sr_c9", st_ready1, 1'b1);
        chk("e_ov_c9", out_valid1, 1'b0);

        // Reset pulse mid-block discards it.
        do_reset();
        st_valid = 1'b1; st_data = {$urandom, $urandom, $urandom, $urandom}; out_ready = 1'b1;
        tick(); st_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0; #1;
        chk("f_ov_rst", out_valid1, 1'b0);
        chk("f_od_rst", out_data1, 128'h0);
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("f_ov_quiet", out_valid1, 1'b0);
            chk("f_kv_quiet", kw_valid1, 1'b0);
        end
        st_valid = 1'b1; st_data = 128'h0;
        tick(); st_valid = 1'b0;
        repeat (4) tick();
        chk("f_ov_zero", out_valid1, 1'b1);
        chk("f_od_zero", out_data1, {16{8'h63}});
        tick();

        // Random blocks with random consumer stalls.
        do_reset();
        for (int n = 0; n < 16; n++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            exp_d = sub_state(d);
            st_valid = 1'b1; st_data = d; out_ready = 1'b0;
            tick(); st_valid = 1'b0;
            cnt = 1; #1;
            while (out_valid1 !== 1'b1 && cnt < 20) begin
                tick(); cnt++; #1;
            end
            chk("g_lat", cnt, 5);
            chk("g_ov0", out_valid0, 1'b1);
            chk("g_od1", out_data1, exp_d);
            chk("g_od0", out_data0, exp_d);
            k = $urandom_range(0, 3);
            repeat (k) tick();
            out_ready = 1'b1; #1;
            chk("g_od_stable", out_data1, exp_d);
            tick(); out_ready = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
